dcache_refill_engine: RTL and testbench
=======================================

// Module: dcache_refill_engine
// PURPOSE
//  Miss/eviction engine between the L1 dCache arbiter and the next memory level. Accepts one miss
//  (plus optional dirty victim), writes the victim back in beats, fetches the missing 128-byte
//  line in beats, then returns the assembled line with a one-cycle fill pulse. Blocking: one miss at a time.
// PARAMETERS
//  LINE_W      1024  line width in bits (b=7, 128 B)
//  MEM_W       64    memory data beat width; BEATS = LINE_W/MEM_W (16 at defaults), must divide evenly
//  ADDR_W      32    byte address width
// PORTS
//  clk             in   1        clock; all state on posedge
//  rst             in   1        reset, asynchronous, active-high
//  miss_valid      in   1        miss request from arbiter
//  miss_ready      out  1        engine idle, request accepted when valid&ready
//  miss_addr       in   ADDR_W   missed byte address
//  evict_valid     in   1        victim dirty, write back first (sampled with miss)
//  evict_addr      in   ADDR_W   victim byte address
//  evict_data      in   LINE_W   victim line
//  mem_cmd_valid   out  1        memory command valid
//  mem_cmd_ready   in   1        memory accepts command
//  mem_cmd_we      out  1        1=line write, 0=line read
//  mem_cmd_addr    out  ADDR_W   line-aligned address (bits [6:0]=0)
//  mem_wvalid      out  1        write beat valid
//  mem_wready      in   1        write beat accepted
//  mem_wdata       out  MEM_W    write beat, beat 0 = line bits [MEM_W-1:0]
//  mem_rvalid      in   1        read beat valid (no backpressure)
//  mem_rdata       in   MEM_W    read beat, same ordering as writes
//  fill_valid      out  1        one-cycle pulse: line ready (drives arbiter repair_resolved)
//  fill_addr       out  ADDR_W   line-aligned address of fill
//  fill_data       out  LINE_W   assembled line, held stable until next accepted miss
//  busy            out  1        state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, beat_cnt=0; miss_ready=1, mem_cmd_valid=0, mem_wvalid=0,
//   fill_valid=0, busy=0, fill_addr=0, fill_data=0, mem_cmd_we=0, mem_cmd_addr=0, mem_wdata=0.
//  FSM: IDLE -> (accept, evict_valid) WB_CMD | (accept, !evict_valid) RD_CMD.
//   WB_CMD: mem_cmd_valid=1, we=1, addr=evict_addr&~7'h7F; on ready -> WB_DATA, beat_cnt=0.
//   WB_DATA: mem_wvalid=1, mem_wdata=victim beat[beat_cnt]; advance on wready;
//    handshake on beat BEATS-1 -> RD_CMD.
//   RD_CMD: cmd_valid=1, we=0, addr=miss_addr&~7'h7F; on ready -> RD_DATA, beat_cnt=0.
//   RD_DATA: each mem_rvalid writes beat_cnt slot; beat BEATS-1 -> DONE.
//   DONE: fill_valid=1 exactly one cycle, fill_addr=aligned miss addr -> IDLE.
//  miss_ready = (state==IDLE); earliest next accept is the cycle after DONE.
//  Latency: accept->RD_CMD valid next cycle; last rvalid -> fill_valid next cycle.
//  Inputs captured on accept; later changes to miss_*/evict_* ignored.
//  mem_cmd_valid/mem_wvalid, once high, hold with stable addr/data until handshake.
//  mem_rvalid outside RD_DATA: ignored, no state change (bench flags as error).
//  beat_cnt width clog2(BEATS); wraps to 0 after last beat, never indexes past BEATS-1.
//  evict_addr line == miss_addr line: legal; writeback still completes before read.
//  Async reset mid-operation: abort, discard partial line/victim, no fill_valid, outputs to reset values.
// STRUCTURE
//  CORE_PKG: LINE_BYTES_LOG2=7, typedef enum refill_state_t {IDLE,WB_CMD,WB_DATA,RD_CMD,RD_DATA,DONE}.
//  Sub-module line_beat_buffer: LINE_W register, beat-indexed write (fill) and read mux (victim),
//   shared between WB and RD phases; single instance.
// TESTING
//  1 clean miss 0x0000_1234, no evict, mem ready=1 -> cmd addr 0x0000_1200 we=0; 16 beats k=k;
//    fill_valid 1 cycle, fill_data beat k=k, fill_addr 0x1200.
//  2 dirty miss: evict 0x0000_8080 data beat k=0xA0+k -> WB cmd 0x8080, 16 wdata beats in order
//    before read cmd; fill correct afterwards.
//  3 backpressure: cmd_ready low 5 cycles, wready toggling 1/0 -> cmd/wdata held stable, no beat
//    skipped or duplicated, 16 write handshakes exactly.
//  4 miss_valid held high through fill -> second accept only cycle after fill_valid; miss_ready=0 while busy.
//  5 async rst asserted at read beat 7 -> outputs to reset values immediately, no fill_valid;
//    new miss afterwards completes normally with fresh data.
//  6 stray mem_rvalid in IDLE/WB_DATA -> no state or fill_data change.

Source files
------------

// File: rtl/dcache_refill_engine_pkg.sv
// -----------------------------------------------------------------------------
// dcache_refill_engine_pkg
// Shared definitions for the L1 dCache miss/eviction engine: the cache line
// geometry and the refill state encoding used by the controller.
// -----------------------------------------------------------------------------
package dcache_refill_engine_pkg;

    // 128-byte lines: the low 7 address bits select a byte within a line.
    localparam int LINE_BYTES_LOG2 = 7;

    typedef enum logic [2:0] {
        IDLE,
        WB_CMD,
        WB_DATA,
        RD_CMD,
        RD_DATA,
        DONE
    } refill_state_t;

endpackage

// File: rtl/dcache_refill_engine_line_beat_buffer.sv
// -----------------------------------------------------------------------------
// dcache_refill_engine_line_beat_buffer
// One cache line of storage, addressed in memory-beat slices. During
// writeback it holds the victim and feeds beats out through the read mux;
// during refill the same storage is overwritten beat by beat with the
// incoming line.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears the line)
//   load_i          load the whole line from load_data_i
//   load_data_i     full-line load value (victim line)
//   wr_en_i         write one beat at wr_idx_i
//   wr_idx_i        beat slot to write
//   wr_data_i       beat write data
//   rd_idx_i        beat slot to read
//   rd_data_o       beat read data
//   line_o          whole stored line
// -----------------------------------------------------------------------------
module dcache_refill_engine_line_beat_buffer #(
    parameter int LINE_W = 1024,
    parameter int MEM_W  = 64,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] load_data_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [MEM_W-1:0]  wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [MEM_W-1:0]  rd_data_o,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;

    // A full-line load and a beat write never coincide in the controller;
    // the load is given priority so the ordering is defined regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_i) begin
            line_q <= load_data_i;
        end else if (wr_en_i) begin
            line_q[int'(wr_idx_i) * MEM_W +: MEM_W] <= wr_data_i;
        end
    end

    assign rd_data_o = line_q[int'(rd_idx_i) * MEM_W +: MEM_W];
    assign line_o    = line_q;

endmodule

// File: rtl/dcache_refill_engine.sv
// -----------------------------------------------------------------------------
// dcache_refill_engine
// Blocking miss engine between the L1 dCache arbiter and the next memory
// level. Accepts one miss (with an optional dirty victim), writes the victim
// back in MEM_W beats, fetches the missing line in beats, then presents the
// assembled line with a one-cycle fill pulse.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   miss_valid_i / miss_ready_o   miss request handshake (ready only when idle)
//   miss_addr_i                   missed byte address
//   evict_valid_i                 victim is dirty and must be written back first
//   evict_addr_i, evict_data_i    victim byte address and line
//   mem_cmd_valid_o/_ready_i      memory command handshake
//   mem_cmd_we_o, mem_cmd_addr_o  1=line write / 0=line read, line-aligned address
//   mem_wvalid_o/_wready_i        write beat handshake
//   mem_wdata_o                   write beat (beat 0 = line bits [MEM_W-1:0])
//   mem_rvalid_i, mem_rdata_i     read beats, same ordering, no backpressure
//   fill_valid_o                  one-cycle pulse when the line is complete
//   fill_addr_o, fill_data_o      line-aligned fill address and assembled line
//   busy_o                        engine is not idle
// -----------------------------------------------------------------------------
module dcache_refill_engine
    import dcache_refill_engine_pkg::*;
#(
    parameter int LINE_W = 1024,
    parameter int MEM_W  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              evict_valid_i,
    input  logic [ADDR_W-1:0] evict_addr_i,
    input  logic [LINE_W-1:0] evict_data_i,
    output logic              mem_cmd_valid_o,
    input  logic              mem_cmd_ready_i,
    output logic              mem_cmd_we_o,
    output logic [ADDR_W-1:0] mem_cmd_addr_o,
    output logic              mem_wvalid_o,
    input  logic              mem_wready_i,
    output logic [MEM_W-1:0]  mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [MEM_W-1:0]  mem_rdata_i,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic              busy_o
);

    localparam int BEATS = LINE_W / MEM_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_BYTES_LOG2) - 1);

    refill_state_t     state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] miss_addr_q;
    logic [ADDR_W-1:0] evict_addr_q;
    logic              accept;
    logic              buf_load;
    logic              buf_we;
    logic [MEM_W-1:0]  buf_rd_data;
    logic [CNT_W-1:0]  beat_cnt_next;

    // Explicit wrap keeps the counter inside 0..BEATS-1 even when BEATS is
    // not a power of two.
    assign beat_cnt_next = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;

    // Addresses are captured (already line-aligned) only on accept, so the
    // arbiter may change miss_*/evict_* freely while a miss is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            if (accept) begin
                miss_addr_q  <= miss_addr_i & ~OFFSET_MASK;
                evict_addr_q <= evict_addr_i & ~OFFSET_MASK;
            end
        end
    end

    // Commands and write beats are pure functions of the registered state,
    // so once valid rises they stay put until the handshake moves the state.
    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        accept          = 1'b0;
        buf_load        = 1'b0;
        buf_we          = 1'b0;
        miss_ready_o    = 1'b0;
        mem_cmd_valid_o = 1'b0;
        mem_cmd_we_o    = 1'b0;
        mem_cmd_addr_o  = '0;
        mem_wvalid_o    = 1'b0;
        mem_wdata_o     = '0;
        fill_valid_o    = 1'b0;

        case (state_q)
            IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    accept     = 1'b1;
                    buf_load   = evict_valid_i;
                    beat_cnt_d = '0;
                    state_d    = evict_valid_i ? WB_CMD : RD_CMD;
                end
            end
            WB_CMD: begin
                mem_cmd_valid_o = 1'b1;
                mem_cmd_we_o    = 1'b1;
                mem_cmd_addr_o  = evict_addr_q;
                if (mem_cmd_ready_i) begin
                    beat_cnt_d = '0;
                    state_d    = WB_DATA;
                end
            end
            WB_DATA: begin
                mem_wvalid_o = 1'b1;
                mem_wdata_o  = buf_rd_data;
                if (mem_wready_i) begin
                    beat_cnt_d = beat_cnt_next;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                mem_cmd_valid_o = 1'b1;
                mem_cmd_addr_o  = miss_addr_q;
                if (mem_cmd_ready_i) begin
                    beat_cnt_d = '0;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (mem_rvalid_i) begin
                    buf_we     = 1'b1;
                    beat_cnt_d = beat_cnt_next;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                fill_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dcache_refill_engine_line_beat_buffer #(
        .LINE_W (LINE_W),
        .MEM_W  (MEM_W),
        .IDX_W  (CNT_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (buf_load),
        .load_data_i (evict_data_i),
        .wr_en_i     (buf_we),
        .wr_idx_i    (beat_cnt_q),
        .wr_data_i   (mem_rdata_i),
        .rd_idx_i    (beat_cnt_q),
        .rd_data_o   (buf_rd_data),
        .line_o      (fill_data_o)
    );

    assign fill_addr_o = miss_addr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_refill_engine.sv
// -----------------------------------------------------------------------------
// tb_dcache_refill_engine
// Scoreboard bench: stimulus pushes the expected memory commands, write beats
// and fills into queues; a negedge monitor pops and compares whenever the DUT
// presents a handshake or a fill pulse. A small memory responder drives the
// ready/read-beat side with configurable backpressure.
// -----------------------------------------------------------------------------
module tb_dcache_refill_engine;

    localparam int LINE_W = 1024;
    localparam int MEM_W  = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / MEM_W;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } fill_t;

    logic              clk;
    logic              rst;
    logic              miss_valid_i;
    logic              miss_ready_o;
    logic [ADDR_W-1:0] miss_addr_i;
    logic              evict_valid_i;
    logic [ADDR_W-1:0] evict_addr_i;
    logic [LINE_W-1:0] evict_data_i;
    logic              mem_cmd_valid_o;
    logic              mem_cmd_ready_i;
    logic              mem_cmd_we_o;
    logic [ADDR_W-1:0] mem_cmd_addr_o;
    logic              mem_wvalid_o;
    logic              mem_wready_i;
    logic [MEM_W-1:0]  mem_wdata_o;
    logic              mem_rvalid_i;
    logic [MEM_W-1:0]  mem_rdata_i;
    logic              fill_valid_o;
    logic [ADDR_W-1:0] fill_addr_o;
    logic [LINE_W-1:0] fill_data_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;

    cmd_t         cmdQ[$];
    logic [63:0]  wQ[$];
    fill_t        fillQ[$];
    logic [63:0]  rdBaseQ[$];

    int cyc = 0;
    int fillCount = 0;
    int expFills = 0;
    int acceptCount = 0;
    int wHsCount = 0;
    int lastFillCyc = -10;
    int lastAccCyc = 0;
    int lastAccPrevFill = 0;

    int          cmdStallCfg = 0;
    int          stallLeft = 0;
    logic        wToggle = 1'b0;
    logic        rdPending = 1'b0;
    logic        sending = 1'b0;
    int          beatIdx = 0;
    logic [63:0] rdBaseCur = '0;
    logic        respRvalid = 1'b0;
    logic [63:0] respRdata = '0;
    logic        strayRvalid = 1'b0;
    logic [63:0] strayData = 64'hDEAD_BEEF_DEAD_BEEF;

    logic [LINE_W-1:0] lastExpLine;

    assign mem_rvalid_i = respRvalid | strayRvalid;
    assign mem_rdata_i  = respRvalid ? respRdata : strayData;

    dcache_refill_engine #(
        .LINE_W (LINE_W),
        .MEM_W  (MEM_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_valid_i    (miss_valid_i),
        .miss_ready_o    (miss_ready_o),
        .miss_addr_i     (miss_addr_i),
        .evict_valid_i   (evict_valid_i),
        .evict_addr_i    (evict_addr_i),
        .evict_data_i    (evict_data_i),
        .mem_cmd_valid_o (mem_cmd_valid_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_cmd_we_o    (mem_cmd_we_o),
        .mem_cmd_addr_o  (mem_cmd_addr_o),
        .mem_wvalid_o    (mem_wvalid_o),
        .mem_wready_i    (mem_wready_i),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .fill_valid_o    (fill_valid_o),
        .fill_addr_o     (fill_addr_o),
        .fill_data_o     (fill_data_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reports the first differing beat so the message stays short.
    task automatic checkLine(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        int bad = 0;
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (act[i*MEM_W +: MEM_W] !== exp[i*MEM_W +: MEM_W]) bad = i;
        end
        checkOutput($sformatf("%s_beat%0d", name, bad), act[bad*MEM_W +: MEM_W], exp[bad*MEM_W +: MEM_W]);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_miss_ready"}, 64'(miss_ready_o), 64'd1);
        checkOutput({tag, "_cmd_valid"}, 64'(mem_cmd_valid_o), 64'd0);
        checkOutput({tag, "_wvalid"}, 64'(mem_wvalid_o), 64'd0);
        checkOutput({tag, "_fill_valid"}, 64'(fill_valid_o), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, "_fill_addr"}, 64'(fill_addr_o), 64'd0);
        checkOutput({tag, "_cmd_we"}, 64'(mem_cmd_we_o), 64'd0);
        checkOutput({tag, "_cmd_addr"}, 64'(mem_cmd_addr_o), 64'd0);
        checkOutput({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
        checkLine({tag, "_fill_data"}, fill_data_o, '0);
    endtask

    // Expected traffic for one miss: optional writeback command and beats,
    // the read command, then the fill with the responder's beat pattern.
    task automatic pushExpect(input logic [31:0] maddr, input logic ev, input logic [31:0] eaddr,
                              input logic [63:0] evBase, input logic [63:0] rBase);
        cmd_t  c;
        fill_t f;
        if (ev) begin
            c.we = 1'b1;
            c.addr = eaddr & 32'hFFFF_FF80;
            cmdQ.push_back(c);
            for (int k = 0; k < BEATS; k++) wQ.push_back(evBase + 64'(k));
        end
        c.we = 1'b0;
        c.addr = maddr & 32'hFFFF_FF80;
        cmdQ.push_back(c);
        rdBaseQ.push_back(rBase);
        f.addr = maddr & 32'hFFFF_FF80;
        for (int k = 0; k < BEATS; k++) f.data[k*MEM_W +: MEM_W] = rBase + 64'(k);
        fillQ.push_back(f);
        lastExpLine = f.data;
        expFills++;
    endtask

    task automatic applyStimulus(input logic [31:0] maddr, input logic ev, input logic [31:0] eaddr,
                                 input logic [63:0] evBase, input logic [63:0] rBase);
        logic [LINE_W-1:0] evLine;
        int n = 0;
        for (int k = 0; k < BEATS; k++) evLine[k*MEM_W +: MEM_W] = evBase + 64'(k);
        pushExpect(maddr, ev, eaddr, evBase, rBase);
        @(posedge clk);
        #1;
        miss_valid_i  = 1'b1;
        miss_addr_i   = maddr;
        evict_valid_i = ev;
        evict_addr_i  = eaddr;
        evict_data_i  = evLine;
        forever begin
            @(negedge clk);
            if (miss_ready_o || n >= 200) break;
            n++;
        end
        if (n >= 200) checkOutput("accept_timeout", 64'(miss_ready_o), 64'd1);
        @(posedge clk);
        #1;
        miss_valid_i  = 1'b0;
        miss_addr_i   = 32'hFFFF_FFFF;
        evict_valid_i = ~ev;
        evict_addr_i  = 32'h5555_5555;
        evict_data_i  = ~evLine;
    endtask

    task automatic waitFills();
        int n = 0;
        while (fillCount < expFills && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("fill_seen", 64'(fillCount), 64'(expFills));
        @(posedge clk);
        #1;
    endtask

    task automatic flushExpect();
        cmdQ.delete();
        wQ.delete();
        fillQ.delete();
        rdBaseQ.delete();
        expFills = fillCount;
    endtask

    // Memory responder: command stalls of cmdStallCfg cycles per command,
    // optional toggling wready, and 16 back-to-back read beats per read.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            respRvalid      = 1'b0;
            sending         = 1'b0;
            rdPending       = 1'b0;
            beatIdx         = 0;
            stallLeft       = cmdStallCfg;
            mem_cmd_ready_i = 1'b1;
            mem_wready_i    = 1'b1;
        end else begin
            if (mem_cmd_valid_o) begin
                if (stallLeft > 0) begin
                    mem_cmd_ready_i = 1'b0;
                    stallLeft--;
                end else begin
                    mem_cmd_ready_i = 1'b1;
                end
            end else begin
                stallLeft       = cmdStallCfg;
                mem_cmd_ready_i = (cmdStallCfg == 0);
            end
            mem_wready_i = wToggle ? ~mem_wready_i : 1'b1;
            if (rdPending) begin
                rdPending = 1'b0;
                sending   = 1'b1;
                beatIdx   = 0;
                rdBaseCur = (rdBaseQ.size() > 0) ? rdBaseQ.pop_front() : 64'd0;
            end
            if (sending) begin
                respRvalid = 1'b1;
                respRdata  = rdBaseCur + 64'(beatIdx);
                beatIdx++;
                if (beatIdx == BEATS) sending = 1'b0;
            end else begin
                respRvalid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake or fill pulse and checks
    // that pending commands/beats hold stable until accepted.
    logic              prevCmdWait = 1'b0;
    logic [ADDR_W-1:0] prevCmdAddr;
    logic              prevCmdWe;
    logic              prevWWait = 1'b0;
    logic [MEM_W-1:0]  prevWData;
    cmd_t              monCmd;
    fill_t             monFill;
    logic [63:0]       monW;

    always @(negedge clk) begin
        if (rst) begin
            prevCmdWait = 1'b0;
            prevWWait   = 1'b0;
        end else begin
            if (prevCmdWait) begin
                checkOutput("cmd_valid_held", 64'(mem_cmd_valid_o), 64'd1);
                checkOutput("cmd_addr_held", 64'(mem_cmd_addr_o), 64'(prevCmdAddr));
                checkOutput("cmd_we_held", 64'(mem_cmd_we_o), 64'(prevCmdWe));
            end
            prevCmdWait = mem_cmd_valid_o && !mem_cmd_ready_i;
            prevCmdAddr = mem_cmd_addr_o;
            prevCmdWe   = mem_cmd_we_o;
            if (mem_cmd_valid_o && mem_cmd_ready_i) begin
                if (cmdQ.size() == 0) begin
                    checkOutput("unexpected_cmd", 64'(mem_cmd_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    monCmd = cmdQ.pop_front();
                    checkOutput("cmd_we", 64'(mem_cmd_we_o), 64'(monCmd.we));
                    checkOutput("cmd_addr", 64'(mem_cmd_addr_o), 64'(monCmd.addr));
                    if (!monCmd.we) checkOutput("wb_done_before_rd", 64'(wQ.size()), 64'd0);
                end
                if (!mem_cmd_we_o) rdPending = 1'b1;
            end

            if (prevWWait) begin
                checkOutput("wvalid_held", 64'(mem_wvalid_o), 64'd1);
                checkOutput("wdata_held", mem_wdata_o, prevWData);
            end
            prevWWait = mem_wvalid_o && !mem_wready_i;
            prevWData = mem_wdata_o;
            if (mem_wvalid_o && mem_wready_i) begin
                wHsCount++;
                if (wQ.size() == 0) begin
                    checkOutput("unexpected_wbeat", mem_wdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    monW = wQ.pop_front();
                    checkOutput("wdata", mem_wdata_o, monW);
                end
            end

            if (fill_valid_o) begin
                fillCount++;
                lastFillCyc = cyc;
                if (fillQ.size() == 0) begin
                    checkOutput("unexpected_fill", 64'(fill_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    monFill = fillQ.pop_front();
                    checkOutput("fill_addr", 64'(fill_addr_o), 64'(monFill.addr));
                    checkLine("fill_data", fill_data_o, monFill.data);
                end
            end

            if (miss_valid_i && miss_ready_o) begin
                acceptCount++;
                lastAccCyc      = cyc;
                lastAccPrevFill = lastFillCyc;
            end

            if (busy_o) checkOutput("ready_while_busy", 64'(miss_ready_o), 64'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int startW;
        int startAcc;
        int n;
        rst             = 1'b1;
        miss_valid_i    = 1'b0;
        miss_addr_i     = '0;
        evict_valid_i   = 1'b0;
        evict_addr_i    = '0;
        evict_data_i    = '0;
        mem_cmd_ready_i = 1'b1;
        mem_wready_i    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        $display("[TB] clean miss");
        applyStimulus(32'h0000_1234, 1'b0, 32'h0, 64'h0, 64'h0);
        waitFills();

        $display("[TB] stray rvalid while idle");
        strayRvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        strayRvalid = 1'b0;
        @(negedge clk);
        checkOutput("stray_idle_busy", 64'(busy_o), 64'd0);
        checkOutput("stray_idle_ready", 64'(miss_ready_o), 64'd1);
        checkLine("stray_idle_fill", fill_data_o, lastExpLine);

        $display("[TB] dirty miss with stray rvalid during writeback");
        applyStimulus(32'h0000_2345, 1'b1, 32'h0000_8080, 64'hA0, 64'h100);
        n = 0;
        while (!mem_wvalid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        strayRvalid = 1'b1;
        @(posedge clk);
        #1;
        strayRvalid = 1'b0;
        waitFills();

        $display("[TB] backpressure on command and write channels");
        cmdStallCfg = 5;
        wToggle     = 1'b1;
        startW      = wHsCount;
        applyStimulus(32'h0000_30F0, 1'b1, 32'h0000_4011, 64'hB00, 64'h200);
        waitFills();
        checkOutput("wb_handshakes", 64'(wHsCount - startW), 64'(BEATS));
        cmdStallCfg = 0;
        wToggle     = 1'b0;

        $display("[TB] miss_valid held through fill");
        startAcc = acceptCount;
        pushExpect(32'h0000_9A00, 1'b0, 32'h0, 64'h0, 64'h300);
        pushExpect(32'h0000_9A00, 1'b0, 32'h0, 64'h0, 64'h300);
        miss_valid_i  = 1'b1;
        miss_addr_i   = 32'h0000_9A00;
        evict_valid_i = 1'b0;
        n = 0;
        while (acceptCount < startAcc + 2 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        miss_valid_i = 1'b0;
        checkOutput("held_accepts", 64'(acceptCount - startAcc), 64'd2);
        checkOutput("accept_after_fill", 64'(lastAccCyc), 64'(lastAccPrevFill + 1));
        waitFills();

        $display("[TB] async reset during read beat 7");
        applyStimulus(32'h0000_5000, 1'b0, 32'h0, 64'h0, 64'h5000);
        n = 0;
        while (!(respRvalid && respRdata == 64'h5007) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_beat7", respRdata, 64'h5007);
        #1;
        rst = 1'b1;
        flushExpect();
        #1;
        checkResetValues("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        checkOutput("no_fill_after_abort", 64'(fillCount), 64'(expFills));
        applyStimulus(32'h0000_6010, 1'b0, 32'h0, 64'h0, 64'h7000);
        waitFills();

        checkOutput("queues_empty", 64'(cmdQ.size() + wQ.size() + fillQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
